// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD driver.
//   - HD44780 command bytes used during init and refresh
//   - top-level sequencer states and bus-write phases
//   - row_offset(): DDRAM start address of a display row
package lcd_pkg;

    localparam logic [7:0] FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, cursor off
    localparam logic [7:0] ENTRY      = 8'h06;  // increment, no shift
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] DDRAM_BASE = 8'h80;
    localparam logic [7:0] SPACE      = 8'h20;

    // Width of the per-write idle counter in the bus writer.
    localparam int WAIT_W = 16;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_ROW_ADDR,
        ST_CHAR,
        ST_GAP
    } lcd_state_t;

    // The SETUP cycle is the cycle start is accepted, so it needs no phase.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_PULSE,
        PH_HOLD
    } bus_phase_t;

    // Rows 2 and 3 of a 4-line panel continue rows 0 and 1 in DDRAM.
    function automatic logic [7:0] row_offset(input logic [1:0] row, input int cols);
        logic [7:0] off;
        case (row)
            2'd0:    off = 8'h00;
            2'd1:    off = 8'h40;
            2'd2:    off = 8'(cols);
            default: off = 8'(8'h40 + cols);
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lcd_bus_write.sv
// One timed write on the LCD bus: SETUP (E=0) -> PULSE (E=1) -> HOLD (E=0).
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_start              accepted while idle; that cycle is the SETUP cycle
//   i_rs, i_data         register select / byte, captured at the end of SETUP
//   i_wait_cyc           idle cycles after E falls (>=1)
//   o_done               high on the last HOLD cycle
//   o_lcd_e/rs/data      LCD pins
module lcd_bus_write
    import lcd_pkg::*;
#(
    parameter int E_HIGH_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_rs,
    input  logic [7:0]        i_data,
    input  logic [WAIT_W-1:0] i_wait_cyc,
    output logic              o_done,
    output logic              o_lcd_e,
    output logic              o_lcd_rs,
    output logic [7:0]        o_lcd_data
);

    bus_phase_t        r_phase, w_phase_nxt;
    logic [WAIT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic              r_rs;
    logic [7:0]        r_data;
    logic              w_accept;

    assign w_accept = (r_phase == PH_IDLE) && i_start;

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        o_done      = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                if (i_start) begin
                    w_phase_nxt = PH_PULSE;
                    w_cnt_nxt   = WAIT_W'(E_HIGH_CYC - 1);
                end
            end
            PH_PULSE: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PH_HOLD;
                    w_cnt_nxt   = r_wait - WAIT_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt - WAIT_W'(1);
                end
            end
            PH_HOLD: begin
                if (r_cnt == '0) begin
                    o_done      = 1'b1;
                    w_phase_nxt = PH_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - WAIT_W'(1);
                end
            end
            default: w_phase_nxt = PH_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_rs   <= i_rs;
                r_data <= i_data;
                r_wait <= i_wait_cyc;
            end
        end
    end

    // E decodes straight from the phase register so a reset drops it at once.
    assign o_lcd_e    = (r_phase == PH_PULSE);
    assign o_lcd_rs   = w_accept ? i_rs   : r_rs;
    assign o_lcd_data = w_accept ? i_data : r_data;

endmodule

// File: rtl/lcd_char_driver.sv
// Character-LCD driver: frame buffer with per-cell blink, power-on init and
// continuous refresh of an HD44780-class panel.
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_wr_en/addr/char/blink          frame-buffer write (addr = row*COLS+col)
//   i_clear_req                      blank the whole buffer in one cycle
//   o_ready                          init complete (held until reset)
//   o_frame_done                     one-cycle pulse after a frame's last cell
//   o_lcd_e/rs/rw/data               LCD pins
//
// state       | meaning
// ------------+---------------------------------------------------
// ST_PWR_WAIT | power-up delay before the first command
// ST_INIT     | function set, display on, entry mode, clear
// ST_ROW_ADDR | set DDRAM address to the start of the current row
// ST_CHAR     | write the current row's characters
// ST_GAP      | idle between frames
module lcd_char_driver
    import lcd_pkg::*;
#(
    parameter int COLS            = 16,
    parameter int ROWS            = 2,
    parameter int E_HIGH_CYC      = 4,
    parameter int CMD_WAIT_CYC    = 50,
    parameter int CLEAR_WAIT_CYC  = 2000,
    parameter int INIT_WAIT_CYC   = 20000,
    parameter int BLINK_DIV       = 500,
    parameter int REFRESH_GAP_CYC = 100
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_wr_en,
    // One spare code point so out-of-range indices can actually be presented.
    input  logic [$clog2(ROWS*COLS+1)-1:0]     i_wr_addr,
    input  logic [7:0]                         i_wr_char,
    input  logic                               i_wr_blink,
    input  logic                               i_clear_req,
    output logic                               o_ready,
    output logic                               o_frame_done,
    output logic                               o_lcd_e,
    output logic                               o_lcd_rs,
    output logic                               o_lcd_rw,
    output logic [7:0]                         o_lcd_data
);

    localparam int NCELL    = ROWS * COLS;
    localparam int AW       = $clog2(NCELL + 1);
    localparam int CW       = $clog2(COLS);
    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WAIT_MAX = (INIT_WAIT_CYC > REFRESH_GAP_CYC) ? INIT_WAIT_CYC : REFRESH_GAP_CYC;
    localparam int TW       = $clog2(WAIT_MAX + 1);
    localparam int BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    lcd_state_t    r_state, w_state_nxt;
    logic [TW-1:0] r_wait, w_wait_nxt;
    logic [1:0]    r_init_idx, w_init_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic          r_busy;
    logic          r_ready;
    logic          r_frame_done;
    logic          r_blink_ph;
    logic [BW-1:0] r_blink_cnt;
    logic [7:0]    r_char  [NCELL];
    logic          r_blink [NCELL];

    logic              w_start, w_rs, w_done;
    logic [7:0]        w_data, w_init_cmd, w_cell_char, w_char_out;
    logic [WAIT_W-1:0] w_bus_wait;
    logic              w_set_ready, w_frame_end, w_cell_blink, w_wr_ok;
    logic [AW-1:0]     w_cell;

    assign w_wr_ok = i_wr_en && !i_clear_req && (i_wr_addr < AW'(NCELL));
    assign w_cell  = AW'(int'(r_row) * COLS + int'(r_col));

    // Sampling bypasses the buffer so a write or clear in the SETUP cycle is
    // what goes out on the bus.
    always_comb begin
        w_cell_char  = r_char[w_cell];
        w_cell_blink = r_blink[w_cell];
        if (i_clear_req) begin
            w_cell_char  = SPACE;
            w_cell_blink = 1'b0;
        end else if (w_wr_ok && (i_wr_addr == w_cell)) begin
            w_cell_char  = i_wr_char;
            w_cell_blink = i_wr_blink;
        end
    end

    // The blink phase only changes at frame end, so it is constant for the
    // whole of every frame.
    assign w_char_out = (w_cell_blink && r_blink_ph) ? SPACE : w_cell_char;

    always_comb begin
        case (r_init_idx)
            2'd0:    w_init_cmd = FUNC_SET;
            2'd1:    w_init_cmd = DISP_ON;
            2'd2:    w_init_cmd = ENTRY;
            default: w_init_cmd = CLEAR;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_init_nxt  = r_init_idx;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_start     = 1'b0;
        w_rs        = 1'b0;
        w_data      = 8'h00;
        w_bus_wait  = WAIT_W'(CMD_WAIT_CYC);
        w_set_ready = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_PWR_WAIT: begin
                if (r_wait == '0) w_state_nxt = ST_INIT;
                else              w_wait_nxt  = r_wait - TW'(1);
            end
            ST_INIT: begin
                w_start = !r_busy;
                w_data  = w_init_cmd;
                if (r_init_idx == 2'd3) w_bus_wait = WAIT_W'(CLEAR_WAIT_CYC);
                if (w_done) begin
                    w_init_nxt = r_init_idx + 2'd1;
                    if (r_init_idx == 2'd3) begin
                        w_set_ready = 1'b1;
                        w_state_nxt = ST_ROW_ADDR;
                    end
                end
            end
            ST_ROW_ADDR: begin
                w_start = !r_busy;
                w_data  = DDRAM_BASE | row_offset(2'(r_row), COLS);
                if (w_done) w_state_nxt = ST_CHAR;
            end
            ST_CHAR: begin
                w_start = !r_busy;
                w_rs    = 1'b1;
                w_data  = w_char_out;
                if (w_done) begin
                    if (r_col == CW'(COLS - 1)) begin
                        w_col_nxt = '0;
                        if (r_row == RW'(ROWS - 1)) begin
                            w_row_nxt   = '0;
                            w_frame_end = 1'b1;
                            if (REFRESH_GAP_CYC == 0) begin
                                w_state_nxt = ST_ROW_ADDR;
                            end else begin
                                w_state_nxt = ST_GAP;
                                w_wait_nxt  = TW'(REFRESH_GAP_CYC - 1);
                            end
                        end else begin
                            w_row_nxt   = r_row + RW'(1);
                            w_state_nxt = ST_ROW_ADDR;
                        end
                    end else begin
                        w_col_nxt = r_col + CW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (r_wait == '0) w_state_nxt = ST_ROW_ADDR;
                else              w_wait_nxt  = r_wait - TW'(1);
            end
            default: w_state_nxt = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_PWR_WAIT;
            r_wait       <= TW'(INIT_WAIT_CYC - 1);
            r_init_idx   <= 2'd0;
            r_row        <= '0;
            r_col        <= '0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b0;
            r_frame_done <= 1'b0;
            r_blink_ph   <= 1'b0;
            r_blink_cnt  <= BW'(BLINK_DIV - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_wait       <= w_wait_nxt;
            r_init_idx   <= w_init_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_frame_done <= w_frame_end;
            if (w_start)     r_busy  <= 1'b1;
            else if (w_done) r_busy  <= 1'b0;
            if (w_set_ready) r_ready <= 1'b1;
            if (w_frame_end) begin
                if (r_blink_cnt == '0) begin
                    r_blink_cnt <= BW'(BLINK_DIV - 1);
                    r_blink_ph  <= ~r_blink_ph;
                end else begin
                    r_blink_cnt <= r_blink_cnt - BW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NCELL; i++) begin
                r_char[i]  <= SPACE;
                r_blink[i] <= 1'b0;
            end
        end else if (i_clear_req) begin
            for (int i = 0; i < NCELL; i++) begin
                r_char[i]  <= SPACE;
                r_blink[i] <= 1'b0;
            end
        end else if (w_wr_ok) begin
            r_char[i_wr_addr]  <= i_wr_char;
            r_blink[i_wr_addr] <= i_wr_blink;
        end
    end

    lcd_bus_write #(
        .E_HIGH_CYC (E_HIGH_CYC)
    ) u_bus (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_start),
        .i_rs       (w_rs),
        .i_data     (w_data),
        .i_wait_cyc (w_bus_wait),
        .o_done     (w_done),
        .o_lcd_e    (o_lcd_e),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_data (o_lcd_data)
    );

    assign o_ready      = r_ready;
    assign o_frame_done = r_frame_done;
    assign o_lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_char_driver.sv
module tb_lcd_char_driver;

    localparam int COLS   = 4;
    localparam int ROWS   = 2;
    localparam int EHIGH  = 2;
    localparam int CMDW   = 3;
    localparam int CLRW   = 8;
    localparam int INITW  = 10;
    localparam int BDIV   = 1;
    localparam int GAP    = 5;
    localparam int NCELL  = ROWS * COLS;
    localparam int AW     = $clog2(NCELL + 1);
    localparam int FLEN   = ROWS * (COLS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_char = 8'h00;
    logic          wr_blink = 1'b0;
    logic          clear_req = 1'b0;
    logic          ready, frame_done, lcd_e, lcd_rs, lcd_rw;
    logic [7:0]    lcd_data;

    lcd_char_driver #(
        .COLS(COLS), .ROWS(ROWS), .E_HIGH_CYC(EHIGH), .CMD_WAIT_CYC(CMDW),
        .CLEAR_WAIT_CYC(CLRW), .INIT_WAIT_CYC(INITW), .BLINK_DIV(BDIV),
        .REFRESH_GAP_CYC(GAP)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_char(wr_char), .i_wr_blink(wr_blink), .i_clear_req(clear_req),
        .o_ready(ready), .o_frame_done(frame_done), .o_lcd_e(lcd_e),
        .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Edges since reset release; read at negedge it equals the edge number.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Bus monitor: one entry {rs,data} per E rise.
    logic [8:0] q[$];
    logic e_prev = 1'b0, ready_prev = 1'b0;
    int   hw = 0, first_rise = -1, last_fall = -1, ready_gap = -1, fd_count = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev = 1'b0; ready_prev = 1'b0; hw = 0; fd_count = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                q.push_back({lcd_rs, lcd_data});
                if (first_rise < 0) first_rise = cyc;
            end
            if (lcd_e) hw++;
            if (!lcd_e && e_prev) begin
                n_cmp++;
                if (hw !== EHIGH) begin
                    n_fail++;
                    $display("FAIL e_high_width: got %0d cycles, expected %0d", hw, EHIGH);
                end
                hw = 0;
                last_fall = cyc;
            end
            if (ready && !ready_prev) ready_gap = cyc - last_fall;
            if (frame_done) fd_count++;
            e_prev = lcd_e;
            ready_prev = ready;
        end
    end

    // Reference model of the frame buffer.
    logic [7:0] m_char [NCELL];
    logic       m_blink[NCELL];

    task automatic model_clear();
        for (int i = 0; i < NCELL; i++) begin
            m_char[i] = 8'h20; m_blink[i] = 1'b0;
        end
    endtask

    task automatic build_frame(input int fidx, output logic [8:0] f[FLEN]);
        int  k = 0;
        logic ph;
        ph = ((fidx / BDIV) % 2) == 1;
        for (int r = 0; r < ROWS; r++) begin
            f[k] = {1'b0, (r == 0) ? 8'h80 : 8'hC0};
            k++;
            for (int c = 0; c < COLS; c++) begin
                f[k] = {1'b1, (m_blink[r*COLS+c] && ph) ? 8'h20 : m_char[r*COLS+c]};
                k++;
            end
        end
    endtask

    task automatic get_write(output logic [8:0] w);
        int t = 0;
        while (q.size() == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL bus_write_timeout: got no E pulse, expected one within 200 cycles");
            w = 9'h1FF;
        end else begin
            w = q.pop_front();
        end
    endtask

    // Returns the index of the frame that follows the boundary.
    task automatic wait_frame_boundary(output int nf);
        int t = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (frame_done !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL frame_done_timeout: got no FRAME_DONE, expected one within 300 cycles");
        end
        #1;
        q.delete();
        nf = fd_count;
    endtask

    task automatic drive_write(input int addr, input logic [7:0] ch, input logic bl, input logic clr);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_char = ch; wr_blink = bl; clear_req = clr;
        @(negedge clk);
        wr_en = 1'b0; clear_req = 1'b0; wr_blink = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (lcd_e !== 1'b0)      begin n_fail++; $display("FAIL reset_e: got %b, expected 0", lcd_e); end
        if (lcd_rs !== 1'b0)     begin n_fail++; $display("FAIL reset_rs: got %b, expected 0", lcd_rs); end
        if (lcd_rw !== 1'b0)     begin n_fail++; $display("FAIL reset_rw: got %b, expected 0", lcd_rw); end
        if (lcd_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got 0x%02h, expected 0x00", lcd_data); end
        if (ready !== 1'b0)      begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", ready); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
    endtask

    task automatic test_init();
        logic [8:0] w;
        logic [8:0] exp_cmd[4];
        int t = 0;
        exp_cmd[0] = 9'h038; exp_cmd[1] = 9'h00C; exp_cmd[2] = 9'h006; exp_cmd[3] = 9'h001;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            get_write(w);
            n_cmp++;
            if (w !== exp_cmd[i]) begin
                n_fail++;
                $display("FAIL init_cmd%0d: got rs=%0b data=0x%02h, expected rs=0 data=0x%02h", i, w[8], w[7:0], exp_cmd[i][7:0]);
            end
        end
        n_cmp++;
        if (first_rise !== INITW + 1) begin
            n_fail++; $display("FAIL first_e_rise: got cycle %0d, expected %0d", first_rise, INITW + 1);
        end
        while (ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        #1;
        n_cmp++;
        if (ready_gap !== CLRW) begin
            n_fail++; $display("FAIL ready_after_clear: got %0d idle cycles, expected %0d", ready_gap, CLRW);
        end
    endtask

    task automatic test_blank_frame();
        logic [8:0] w;
        logic [8:0] f[FLEN];
        int nf;
        for (int fr = 0; fr < 2; fr++) begin
            build_frame(fr, f);
            for (int i = 0; i < FLEN; i++) begin
                get_write(w);
                n_cmp++;
                if (w !== f[i]) begin
                    n_fail++;
                    $display("FAIL blank_frame%0d_slot%0d: got rs=%0b data=0x%02h, expected rs=%0b data=0x%02h", fr, i, w[8], w[7:0], f[i][8], f[i][7:0]);
                end
            end
            wait_frame_boundary(nf);
            n_cmp++;
            if (nf !== fr + 1) begin
                n_fail++; $display("FAIL frame_done_count: got %0d, expected %0d", nf, fr + 1);
            end
        end
    endtask

    task automatic test_write();
        logic [8:0] w;
        logic [8:0] f[FLEN];
        int nf;
        wait_frame_boundary(nf);
        drive_write(5, 8'h41, 1'b0, 1'b0);
        drive_write(8, 8'h55, 1'b0, 1'b0);
        m_char[5] = 8'h41;
        build_frame(nf, f);
        for (int i = 0; i < FLEN; i++) begin
            get_write(w);
            n_cmp++;
            if (w !== f[i]) begin
                n_fail++;
                $display("FAIL write_slot%0d: got rs=%0b data=0x%02h, expected rs=%0b data=0x%02h", i, w[8], w[7:0], f[i][8], f[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] w;
        logic [8:0] f[FLEN];
        int nf;
        wait_frame_boundary(nf);
        for (int a = 1; a <= 3; a++) begin
            drive_write(a, 8'(8'h60 + a), 1'b0, 1'b0);
            m_char[a] = 8'(8'h60 + a);
        end
        build_frame(nf, f);
        for (int i = 0; i < FLEN; i++) begin
            get_write(w);
            n_cmp++;
            if (w !== f[i]) begin
                n_fail++;
                $display("FAIL b2b_slot%0d: got rs=%0b data=0x%02h, expected rs=%0b data=0x%02h", i, w[8], w[7:0], f[i][8], f[i][7:0]);
            end
        end
    endtask

    task automatic test_blink();
        logic [8:0] w;
        logic [8:0] f[FLEN];
        int nf;
        wait_frame_boundary(nf);
        drive_write(0, 8'h39, 1'b1, 1'b0);
        m_char[0] = 8'h39; m_blink[0] = 1'b1;
        for (int fr = 0; fr < 2; fr++) begin
            build_frame(nf, f);
            for (int i = 0; i < FLEN; i++) begin
                get_write(w);
                n_cmp++;
                if (w !== f[i]) begin
                    n_fail++;
                    $display("FAIL blink_frame%0d_slot%0d: got rs=%0b data=0x%02h, expected rs=%0b data=0x%02h", nf, i, w[8], w[7:0], f[i][8], f[i][7:0]);
                end
            end
            wait_frame_boundary(nf);
        end
    endtask

    task automatic test_clear();
        logic [8:0] w;
        logic [8:0] f[FLEN];
        int nf;
        wait_frame_boundary(nf);
        drive_write(0, 8'h41, 1'b0, 1'b1);
        model_clear();
        build_frame(nf, f);
        for (int i = 0; i < FLEN; i++) begin
            get_write(w);
            n_cmp++;
            if (w !== f[i]) begin
                n_fail++;
                $display("FAIL clear_slot%0d: got rs=%0b data=0x%02h, expected rs=%0b data=0x%02h", i, w[8], w[7:0], f[i][8], f[i][7:0]);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [8:0] w;
        int t = 0;
        while (lcd_e !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        n_cmp++;
        if (lcd_e !== 1'b1) begin
            n_fail++; $display("FAIL find_pulse: got E=%b, expected 1", lcd_e);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL async_e_drop: got %b, expected 0", lcd_e); end
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_drop: got %b, expected 0", ready); end
        repeat (2) @(negedge clk);
        q.delete();
        first_rise = -1;
        model_clear();
        rst_n = 1'b1;
        get_write(w);
        n_cmp += 2;
        if (w !== 9'h038) begin
            n_fail++; $display("FAIL restart_cmd: got rs=%0b data=0x%02h, expected rs=0 data=0x38", w[8], w[7:0]);
        end
        if (first_rise !== INITW + 1) begin
            n_fail++; $display("FAIL restart_first_rise: got cycle %0d, expected %0d", first_rise, INITW + 1);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_init();
        test_blank_frame();
        test_write();
        test_back_to_back();
        test_blink();
        test_clear();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
